// File: rtl/johnson_seq_ctrl.sv
// Output-path sequencer: chooses between registered pass-through of pass_in and a
// Johnson pattern generator, driven by a valid/ready command port with a step divider.
module johnson_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             abort,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [DIV_W-1:0] cmd_arg,
   input  logic [WIDTH-1:0] pass_in,
   output logic [WIDTH-1:0] out_data,
   output logic             done,
   output logic             busy,
   output logic [1:0]       mode
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PASS = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam logic [1:0] OP_STOP   = 2'd0;
   localparam logic [1:0] OP_PASS   = 2'd1;
   localparam logic [1:0] OP_SETDIV = 2'd3;

   state_t           state;
   logic [WIDTH-1:0] johnson;
   logic [WIDTH-1:0] johnson_nxt;
   logic [DIV_W-1:0] div_reg;
   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] step_cnt;
   logic [DIV_W-1:0] step_tgt;
   logic [DIV_W-1:0] step_nxt;
   logic             bounded;
   logic             accept;

   // Handshake: a transfer happens on any rising edge where cmd_valid & cmd_ready.
   // A bounded run refuses commands so it can only end by completion, abort or reset.
   assign bounded     = (step_tgt != '0);
   assign cmd_ready   = ena & ~abort & ~((state == RUN) & bounded);
   assign accept      = cmd_valid & cmd_ready;
   assign johnson_nxt = {johnson[WIDTH-2:0], ~johnson[WIDTH-1]};
   assign step_nxt    = step_cnt + DIV_W'(1);
   assign busy        = (state != IDLE);
   assign mode        = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         out_data <= '0;
         johnson  <= '0;
         div_reg  <= '0;
         div_cnt  <= '0;
         step_cnt <= '0;
         step_tgt <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (ena) begin
            if (abort) begin
               state <= IDLE;
            end else if (accept && (cmd_op != OP_SETDIV)) begin
               case (cmd_op)
                  OP_STOP: state <= IDLE;
                  OP_PASS: state <= PASS;
                  default: begin
                     state    <= RUN;
                     step_tgt <= cmd_arg;
                     step_cnt <= '0;
                     div_cnt  <= '0;
                     johnson  <= '0;
                     out_data <= '0;
                  end
               endcase
            end else begin
               // SETDIV leaves the state alone but restarts the divider phase.
               if (accept) begin
                  div_reg <= cmd_arg;
                  div_cnt <= '0;
               end
               case (state)
                  PASS: out_data <= pass_in;
                  RUN: begin
                     if (!accept) begin
                        if (div_cnt == div_reg) begin
                           div_cnt  <= '0;
                           johnson  <= johnson_nxt;
                           out_data <= johnson_nxt;
                           step_cnt <= step_nxt;
                           if (bounded && (step_nxt == step_tgt)) begin
                              state <= IDLE;
                              done  <= 1'b1;
                           end
                        end else begin
                           div_cnt <= div_cnt + DIV_W'(1);
                        end
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: doc/johnson_seq_ctrl.md
# johnson_seq_ctrl

Sequencing controller for the 8-bit registered output path of the tile. It arbitrates the output register between a clocked pass-through of the dedicated inputs and an internal 8-bit Johnson pattern generator. The source is selected through a valid/ready command interface, with a programmable step-rate divider and bounded or free-running pattern runs. It sits between the pin-level wrapper (ui_in / uo_out) and the command decoder.

## Interface
- WIDTH, 8, output / pattern width (Johnson period = 2*WIDTH)
- DIV_W, 8, divider and step-count register width
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ena  in  1  global enable; low freezes all state
- abort  in  1  force IDLE, qualified by ena
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accept; transfer on cmd_valid & cmd_ready at a rising edge
- cmd_op  in  2  0=STOP, 1=PASS, 2=RUN, 3=SETDIV
- cmd_arg  in  DIV_W  RUN: step count (0 = free run); SETDIV: divider value
- pass_in  in  WIDTH  pass-through source
- out_data  out  WIDTH  registered output
- done  out  1  one-cycle pulse on bounded-run completion
- busy  out  1  state != IDLE
- mode  out  2  0=IDLE, 1=PASS, 2=RUN

## Operation
- States: IDLE (out_data held), PASS, RUN.
- cmd_ready is combinational: ena & ~abort & ~(state==RUN & step_tgt!=0). A bounded run can only be left by completion, abort or reset.
- STOP goes to IDLE and holds out_data. STOP in IDLE is a no-op.
- PASS goes to PASS. Each subsequent enabled edge does out_data <= pass_in.
- RUN, from any state:
  - step_tgt <= cmd_arg, step_cnt <= 0, div_cnt <= 0.
  - The Johnson register and out_data are cleared to 0.
  - Goes to RUN.
- SETDIV does div_reg <= cmd_arg and div_cnt <= 0. The state is unchanged. It is accepted in IDLE, PASS and free run.
- Tick: in RUN, div_cnt increments each enabled cycle. When div_cnt == div_reg, a tick occurs and div_cnt <= 0. With div_reg = 0, every enabled cycle is a tick.
- On a tick:
  - johnson <= {johnson[WIDTH-2:0], ~johnson[WIDTH-1]}
  - out_data <= that same next value
  - step_cnt <= step_cnt + 1
- Bounded completion: on the tick where step_cnt+1 == step_tgt, the final pattern is registered, the state goes to IDLE, and done is asserted on the next cycle for exactly one cycle.
- Free run (step_tgt = 0): step_cnt is not compared and wraps modulo 2^DIV_W. The pattern wraps with period 2*WIDTH.
- abort with ena high goes to IDLE and holds out_data. done is not asserted, and abort has priority over any command. With ena low, abort is ignored.
- ena low:
  - No state, counter, out_data or done change. done does not stay high: it deasserts on the next edge regardless of ena.
  - cmd_ready is 0.
- Reset values:
  - State IDLE, out_data 0, johnson 0, div_reg 0, div_cnt 0, step_cnt 0, step_tgt 0, done 0.
  - busy 0, mode 0. cmd_ready equals ena.

## Timing
- Command accepted at edge N: the new state is visible after N.
- PASS: pass_in sampled at edge N+k appears on out_data after N+k (k ≥ 1), i.e. one register of latency.
- RUN: out_data = 0 after N. The first step lands at edge N+div_reg+1, and each later step follows after another div_reg+1 enabled cycles.
- Bounded run with arg S: the last step lands at edge N+S*(div_reg+1). done is high during the following cycle, and cmd_ready rises in that same cycle.
- Simultaneous completion tick and cmd_valid: the command is not accepted (cmd_ready was 0).
- Reset mid-run: the next cycle shows the reset values. No done pulse.

## Test plan
- Reset, then PASS with div irrelevant; drive pass_in = A5, 3C on consecutive cycles → out_data = A5, 3C, each one cycle later; mode = 1, busy = 1.
- SETDIV 0, RUN arg 3 → out_data 00, 01, 03, 07 on consecutive edges. done pulses once after 07, then mode = 0 and out_data holds 07. cmd_ready is 0 throughout the run.
- SETDIV 2, RUN arg 0 (free run) → a new step every 3 cycles. After 16 steps out_data returns to 00 (…, C0, 80, 00). STOP then freezes out_data.
- Bounded RUN arg 10 with ena low for 5 cycles mid-run → the pattern and counters freeze. The total steps still equal 10, and done occurs 5 cycles later than without the pause.
- Abort during a bounded run at pattern 1F → IDLE, out_data stays 1F, no done. The same-cycle cmd_valid PASS is not accepted.
- rst asserted mid free run → the next cycle shows out_data = 00, mode = 0, div_reg = 0. A subsequent RUN arg 1 steps once, to 01.
